// File: rtl/ads5296_cal_pkg.sv
// Shared types and helpers for the ADS5296 IDELAY calibration controller.
package ads5296_cal_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_NEXT,
    S_CENTER, S_CLOAD, S_CSETTLE, S_VTC_ON, S_DONE, S_FAIL
  } cal_state_e;

  // Bit w set => 4-bit word w has at most one transition:
  // {0000,0001,0011,0111,1000,1100,1110,1111}.
  localparam logic [15:0] FCLK_OK_MASK = 16'hD18B;

  function automatic logic fclk_word_ok(input logic [3:0] w);
    return FCLK_OK_MASK[w];
  endfunction

endpackage

// File: rtl/ads5296_delay_cal_if.sv
// Control/status bundle between the calibration controller and the receive path.
interface ads5296_delay_cal_if #(parameter int TAP_W = 9);
  logic             start;
  logic [3:0]       fclk4b;
  logic [TAP_W-1:0] delay_val;
  logic             delay_load;
  logic             delay_en_vtc;
  logic             busy;
  logic             done;
  logic             fail;
  logic [TAP_W-1:0] eye_start;
  logic [7:0]       eye_len;

  modport master (
    input  start, fclk4b,
    output delay_val, delay_load, delay_en_vtc, busy, done, fail, eye_start, eye_len
  );
  modport slave (
    output start, fclk4b,
    input  delay_val, delay_load, delay_en_vtc, busy, done, fail, eye_start, eye_len
  );
endinterface

// File: rtl/ads5296_run_tracker.sv
// Tracks the current run of passing taps and keeps the first longest one seen.
module ads5296_run_tracker #(
  parameter int TAP_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step_valid,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  input  logic             close,
  output logic [TAP_W-1:0] best_start,
  output logic [7:0]       best_len
);
  logic [TAP_W-1:0] cur_start;
  logic [7:0]       cur_len;

  // cur_len == 0 means no run is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (step_valid && pass) begin
      if (cur_len == 8'd0) begin
        cur_start <= tap;
        cur_len   <= 8'd1;
      end else if (cur_len != 8'hFF) begin
        cur_len <= cur_len + 8'd1;
      end
    end else if ((step_valid && !pass) || close) begin
      // strict compare: on a tie the earlier run is kept
      if (cur_len > best_len) begin
        best_start <= cur_start;
        best_len   <= cur_len;
      end
      cur_len <= '0;
    end
  end
endmodule

// File: rtl/ads5296_delay_cal.sv
// IDELAY sweep controller: probes fclk at each tap, centres on the widest clean eye.
module ads5296_delay_cal
  import ads5296_cal_pkg::*;
#(
  parameter int TAP_W    = 9,
  parameter int TAP_MAX  = 511,
  parameter int TAP_STEP = 8,
  parameter int VTC_WAIT = 16,
  parameter int SETTLE   = 16,
  parameter int WINDOW   = 1024,
  parameter int MIN_EYE  = 3
) (
  input logic                 clk,
  input logic                 rst,
  ads5296_delay_cal_if.master cal
);
  localparam int CNT_W = 16;

  cal_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d, val_q, val_d, eye_start_q, eye_start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       eye_len_q, eye_len_d;
  logic glitch_q, glitch_d, load_q, load_d, vtc_q, vtc_d;
  logic busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic trk_clear, trk_step, trk_close;
  logic [TAP_W-1:0] best_start, ctr;
  logic [7:0]       best_len;
  logic [TAP_W:0]   tap_sum;

  assign tap_sum = {1'b0, tap_q} + (TAP_W+1)'(TAP_STEP);
  assign ctr = TAP_W'(32'(best_start) + ((32'(best_len - 8'd1) * 32'(TAP_STEP)) >> 1));

  ads5296_run_tracker #(.TAP_W(TAP_W)) u_trk (
    .clk(clk), .rst(rst), .clear(trk_clear), .step_valid(trk_step), .pass(!glitch_q),
    .tap(tap_q), .close(trk_close), .best_start(best_start), .best_len(best_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; tap_q <= '0; cnt_q <= '0; glitch_q <= 1'b0;
      val_q <= '0; load_q <= 1'b0; vtc_q <= 1'b1;
      busy_q <= 1'b0; done_q <= 1'b0; fail_q <= 1'b0;
      eye_start_q <= '0; eye_len_q <= '0;
    end else begin
      state_q <= state_d; tap_q <= tap_d; cnt_q <= cnt_d; glitch_q <= glitch_d;
      val_q <= val_d; load_q <= load_d; vtc_q <= vtc_d;
      busy_q <= busy_d; done_q <= done_d; fail_q <= fail_d;
      eye_start_q <= eye_start_d; eye_len_q <= eye_len_d;
    end
  end

  always_comb begin
    state_d = state_q; tap_d = tap_q; cnt_d = cnt_q + CNT_W'(1); glitch_d = glitch_q;
    val_d = val_q; load_d = 1'b0; vtc_d = vtc_q;
    busy_d = busy_q; done_d = done_q; fail_d = fail_q;
    eye_start_d = eye_start_q; eye_len_d = eye_len_q;
    trk_clear = 1'b0; trk_step = 1'b0; trk_close = 1'b0;
    case (state_q)
      S_VTC_OFF: if (cnt_q == CNT_W'(VTC_WAIT-1)) begin
        state_d = S_LOAD; tap_d = '0; cnt_d = '0;
      end
      // first cycle presents the tap, second cycle strobes the load
      S_LOAD, S_CLOAD: begin
        if (cnt_q == '0) val_d = tap_q;
        else begin
          load_d  = 1'b1;
          cnt_d   = '0;
          state_d = (state_q == S_LOAD) ? S_SETTLE : S_CSETTLE;
        end
      end
      S_SETTLE: if (cnt_q == CNT_W'(SETTLE-1)) begin
        state_d = S_CHECK; cnt_d = '0; glitch_d = 1'b0;
      end
      S_CHECK: begin
        glitch_d = glitch_q | !fclk_word_ok(cal.fclk4b);
        if (cnt_q == CNT_W'(WINDOW-1)) state_d = S_EVAL;
      end
      S_EVAL: begin
        trk_step = 1'b1;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        cnt_d = '0;
        if (tap_sum > (TAP_W+1)'(TAP_MAX)) begin
          trk_close = 1'b1;
          state_d   = S_CENTER;
        end else begin
          tap_d   = tap_sum[TAP_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_CENTER: begin
        eye_start_d = best_start;
        eye_len_d   = best_len;
        cnt_d       = '0;
        if (best_len < 8'(MIN_EYE)) begin
          state_d = S_FAIL; fail_d = 1'b1; busy_d = 1'b0; vtc_d = 1'b1;
        end else begin
          state_d = S_CLOAD; tap_d = ctr;
        end
      end
      S_CSETTLE: if (cnt_q == CNT_W'(SETTLE-1)) state_d = S_VTC_ON;
      S_VTC_ON: begin
        vtc_d = 1'b1; done_d = 1'b1; busy_d = 1'b0; state_d = S_DONE;
      end
      // park the delay line at tap 0 with a single load
      S_FAIL: begin
        cnt_d = cnt_q;
        if (cnt_q == '0) begin
          val_d = '0; vtc_d = 1'b1; cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          load_d = 1'b1; cnt_d = CNT_W'(2);
        end
      end
      S_IDLE, S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    if (cal.start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL)) begin
      state_d = S_VTC_OFF; cnt_d = '0; load_d = 1'b0; vtc_d = 1'b0;
      busy_d = 1'b1; done_d = 1'b0; fail_d = 1'b0; trk_clear = 1'b1;
    end
  end

  assign cal.delay_val    = val_q;
  assign cal.delay_load   = load_q;
  assign cal.delay_en_vtc = vtc_q;
  assign cal.busy         = busy_q;
  assign cal.done         = done_q;
  assign cal.fail         = fail_q;
  assign cal.eye_start    = eye_start_q;
  assign cal.eye_len      = eye_len_q;
endmodule

// File: tb/tb_ads5296_delay_cal.sv
// Directed bench for ads5296_delay_cal: tap-pass patterns driven from delay_val, eye model in plain arithmetic.
module tb_ads5296_delay_cal;
  localparam int TAP_W = 9, TAP_MAX = 511, TAP_STEP = 8, VTC_WAIT = 16;
  localparam int SETTLE = 16, WINDOW = 8, MIN_EYE = 3;

  logic clk, rst;
  ads5296_delay_cal_if #(.TAP_W(TAP_W)) cal_if ();

  ads5296_delay_cal #(
    .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .TAP_STEP(TAP_STEP), .VTC_WAIT(VTC_WAIT),
    .SETTLE(SETTLE), .WINDOW(WINDOW), .MIN_EYE(MIN_EYE)
  ) dut (.clk(clk), .rst(rst), .cal(cal_if));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int vec = 0, err = 0;
  int mode = 1;
  int exp_q[$];
  int m_start, m_len, m_val;
  bit m_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which taps see a clean frame clock in each scenario.
  function automatic bit tap_pass(input int m, input int t);
    case (m)
      2: return (t >= 96 && t < 320);
      3: return (t >= 40 && t <= 72) || (t >= 200 && t <= 232);
      4: return (t == 8 || t == 16);
      5: return (t != 128);
      default: return 1'b1;
    endcase
  endfunction

  // Expected load sequence and eye from the pass map.
  task automatic build_model(input int m);
    int cs, cl;
    exp_q.delete();
    m_start = 0; m_len = 0; cs = 0; cl = 0;
    for (int t = 0; t <= TAP_MAX; t += TAP_STEP) begin
      exp_q.push_back(t);
      if (tap_pass(m, t)) begin
        if (cl == 0) cs = t;
        cl++;
      end else begin
        if (cl > m_len) begin m_start = cs; m_len = cl; end
        cl = 0;
      end
    end
    if (cl > m_len) begin m_start = cs; m_len = cl; end
    m_fail = (m_len < MIN_EYE);
    m_val  = m_fail ? 0 : m_start + ((m_len - 1) * TAP_STEP) / 2;
    exp_q.push_back(m_val);
  endtask

  // fclk driver: 1111100000 serialized, with scenario glitches.
  logic [3:0] clean_w [5] = '{4'b1111, 4'b1000, 4'b0011, 4'b1110, 4'b0000};
  int widx = 0, since = 0;
  initial begin
    cal_if.fclk4b = 4'b1111;
    forever begin
      @(negedge clk);
      since = cal_if.delay_load ? 0 : since + 1;
      widx  = (widx + 1) % 5;
      cal_if.fclk4b = clean_w[widx];
      if (mode >= 2 && mode <= 4 && !tap_pass(mode, int'(cal_if.delay_val)))
        cal_if.fclk4b = 4'b0101;
      if (mode == 5 && cal_if.delay_val == 9'd128 && since == SETTLE + WINDOW - 1)
        cal_if.fclk4b = 4'b1011;
    end
  end

  // Load handshake and sequence compare.
  logic prev_load = 1'b0;
  logic [TAP_W-1:0] prev_val = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (cal_if.delay_load) chk("load_in_reset", cal_if.delay_load, 0);
      prev_load = 1'b0;
      prev_val  = cal_if.delay_val;
    end else begin
      if (cal_if.delay_load) begin
        chk("load_width", prev_load, 0);
        chk("load_setup", cal_if.delay_val, prev_val);
        if (cal_if.busy) chk("load_vtc", cal_if.delay_en_vtc, 0);
        if (exp_q.size() == 0) chk("load_extra", cal_if.delay_val, 9'h1FF);
        else chk("load_val", cal_if.delay_val, exp_q.pop_front());
      end
      prev_load = cal_if.delay_load;
      prev_val  = cal_if.delay_val;
    end
  end

  task automatic pulse_start();
    @(negedge clk) cal_if.start = 1'b1;
    @(negedge clk) cal_if.start = 1'b0;
  endtask

  task automatic run(input int m, input bit e_fail, input int e_start, input int e_len,
                     input int e_val, input bit mid_start);
    mode = m;
    build_model(m);
    chk("model_start", m_start, e_start);
    chk("model_len", m_len, e_len);
    chk("model_val", m_val, e_val);
    pulse_start();
    chk("busy_after_start", cal_if.busy, 1);
    chk("done_cleared", cal_if.done | cal_if.fail, 0);
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (mid_start) cal_if.start = (n == 200);
      if (cal_if.done || cal_if.fail) break;
    end
    cal_if.start = 1'b0;
    chk("finished", cal_if.done | cal_if.fail, 1);
    chk("done", cal_if.done, !m_fail);
    chk("fail", cal_if.fail, m_fail);
    chk("eye_start", cal_if.eye_start, m_start);
    chk("eye_len", cal_if.eye_len, m_len);
    repeat (4) @(negedge clk);
    chk("final_val", cal_if.delay_val, e_val);
    chk("final_vtc", cal_if.delay_en_vtc, 1);
    chk("final_busy", cal_if.busy, 0);
    chk("loads_seen", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_val"}, cal_if.delay_val, 0);
    chk({tag, "_load"}, cal_if.delay_load, 0);
    chk({tag, "_vtc"}, cal_if.delay_en_vtc, 1);
    chk({tag, "_busy"}, cal_if.busy, 0);
    chk({tag, "_done"}, cal_if.done, 0);
    chk({tag, "_fail"}, cal_if.fail, 0);
    chk({tag, "_eye_start"}, cal_if.eye_start, 0);
    chk({tag, "_eye_len"}, cal_if.eye_len, 0);
  endtask

  initial begin
    rst = 1'b1;
    cal_if.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;

    run(1, 0, 0,   64, 252, 0);
    run(2, 0, 96,  28, 204, 1);
    run(3, 0, 40,  5,  56,  0);
    run(4, 1, 8,   2,  0,   0);
    run(5, 0, 136, 47, 320, 0);

    // Abort mid-CHECK with async reset, then recalibrate.
    mode = 1;
    build_model(1);
    pulse_start();
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (cal_if.delay_load && cal_if.delay_val == 9'd64) break;
    end
    chk("reached_tap64", cal_if.delay_val, 64);
    repeat (SETTLE + 3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    run(1, 0, 0, 64, 252, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
